store_monitor: RTL and testbench

// - Observes the data-memory write port of the single-cycle core (memwrite, dataadr, writedata) every clock.
// - Logs each store into an in-order FIFO that the bench can drain.
// - Detects the end-of-program signature store and reports pass or fail.
// - Times out a program that never produces a verdict.

---
 rtl/store_monitor_pkg.sv | 10 +
 rtl/store_log_fifo.sv | 42 ++++
 rtl/store_monitor.sv | 83 ++++++++
 tb/tb_store_monitor.sv | 138 +++++++++++++
 4 files changed

// File: rtl/store_monitor_pkg.sv
// store_monitor_pkg: shared state, verdict and log-entry types for the store monitor
package store_monitor_pkg;
  localparam int STORE_W = 32;
  typedef enum logic [1:0] {RUN, PASS, FAIL} state_t;
  typedef enum logic [1:0] {FC_NONE, FC_DATA, FC_TIMEOUT, FC_XBUS} fail_code_t;
  typedef struct packed {
    logic [STORE_W-1:0] addr;
    logic [STORE_W-1:0] data;
  } store_t;
endpackage

// File: rtl/store_log_fifo.sv
// store_log_fifo: show-ahead FIFO of store entries with true occupancy count; the head holds its last value when empty
module store_log_fifo
  import store_monitor_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter type T = store_t
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  T                        din,
  output T                        dout,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);
  T mem [DEPTH];
  T last;
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? last : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      last <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      last <= empty ? last : mem[rp];
    end
endmodule

// File: rtl/store_monitor.sv
// store_monitor: logs core stores, detects the pass signature or timeout; optional X-check via STORE_MONITOR_XCHECK_EN
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int PASS_ADDR = 84,
  parameter int PASS_DATA = 7,
  parameter int TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    memwrite,
  input  logic [WIDTH-1:0]        dataadr,
  input  logic [WIDTH-1:0]        writedata,
  input  logic                    rd_en,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_addr,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    done,
  output logic                    pass,
  output logic [1:0]              fail_code,
  output logic [31:0]             cycles
);
  typedef struct packed {
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] data;
  } entry_t;
  state_t state, state_n;
  fail_code_t fc, fc_n;
  entry_t head;
  logic full, empty, xbad, sig, push;
`ifdef STORE_MONITOR_XCHECK_EN
  assign xbad = $isunknown(memwrite) || (memwrite === 1'b1 && $isunknown({dataadr, writedata}));
  always_ff @(posedge clk)
    if (reset && state == RUN && xbad) $error("store_monitor: X on store bus at cycle %0d", cycles);
`else
  assign xbad = 1'b0;
`endif
  assign sig = memwrite && dataadr == WIDTH'(PASS_ADDR);
  assign push = state == RUN && memwrite && !xbad;
  always_comb begin
    state_n = state;
    fc_n = fc;
    if (state == RUN) begin
      fc_n = xbad ? FC_XBUS :
             sig && writedata != WIDTH'(PASS_DATA) ? FC_DATA :
             !sig && cycles == 32'(TIMEOUT - 1) ? FC_TIMEOUT : FC_NONE;
      state_n = fc_n != FC_NONE ? FAIL : sig ? PASS : RUN;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= RUN;
      fc <= FC_NONE;
      cycles <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      fc <= fc_n;
      cycles <= state == RUN ? cycles + 32'd1 : cycles;
      overflow <= overflow | (push && full && !rd_en);
    end
  store_log_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_log (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (rd_en),
    .din   ('{addr: dataadr, data: writedata}),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  assign rd_valid = !empty;
  assign rd_addr = head.addr;
  assign rd_data = head.data;
  assign done = state != RUN;
  assign pass = state == PASS;
  assign fail_code = fc;
endmodule

// File: tb/tb_store_monitor.sv
// tb_store_monitor: table-driven and directed checks of store_monitor
module tb_store_monitor;
  logic clk = 0, reset = 0, memwrite = 0, rd_en = 0;
  logic [31:0] dataadr = 0, writedata = 0;
  logic rd_valid, overflow, done, pass;
  logic [31:0] rd_addr, rd_data, cycles;
  logic [3:0] count;
  logic [1:0] fail_code;
  int n_run = 0, n_fail = 0;
  store_monitor #(.WIDTH(32), .DEPTH(8), .PASS_ADDR(84), .PASS_DATA(7), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .rd_en(rd_en), .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .count(count),
    .overflow(overflow), .done(done), .pass(pass), .fail_code(fail_code), .cycles(cycles)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic mw; logic [31:0] a, d; logic rd;
    int cnt; logic rv; logic [31:0] ea, ed; logic dn, ps; int fc, cyc;
  } vec_t;
  vec_t v[16];
  function automatic vec_t row(logic mw, logic [31:0] a, d, logic rd, int cnt, logic rv,
                               logic [31:0] ea, ed, logic dn, ps, int fc, cyc);
    row = '{mw, a, d, rd, cnt, rv, ea, ed, dn, ps, fc, cyc};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input int cnt, input logic rv, input logic [31:0] ea, ed,
                         input logic dn, ps, input int fc, cyc, input logic ovf);
    chk({nm, ".count"}, 32'(count), cnt);
    chk({nm, ".rd_valid"}, 32'(rd_valid), 32'(rv));
    chk({nm, ".rd_addr"}, rd_addr, ea);
    chk({nm, ".rd_data"}, rd_data, ed);
    chk({nm, ".done"}, 32'(done), 32'(dn));
    chk({nm, ".pass"}, 32'(pass), 32'(ps));
    chk({nm, ".fail_code"}, 32'(fail_code), fc);
    chk({nm, ".cycles"}, cycles, cyc);
    chk({nm, ".overflow"}, 32'(overflow), 32'(ovf));
  endtask
  task automatic step(input logic mw, input logic [31:0] a, d, input logic rd);
    memwrite = mw;
    dataadr = a;
    writedata = d;
    rd_en = rd;
    @(posedge clk);
    #1;
    memwrite = 0;
    rd_en = 0;
  endtask
  task automatic restart();
    reset = 0;
    memwrite = 0;
    rd_en = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
  endtask
  logic [31:0] exp_a [8];
  logic [31:0] exp_d [8];
  initial begin
    for (int i = 0; i < 4; i++) v[i] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i + 1);
    v[4] = row(1, 80, 3, 0, 1, 1, 80, 3, 0, 0, 0, 5);
    for (int i = 5; i < 10; i++) v[i] = row(0, 0, 0, 0, 1, 1, 80, 3, 0, 0, 0, i + 1);
    v[10] = row(1, 84, 7, 0, 2, 1, 80, 3, 1, 1, 0, 11);
    v[11] = row(0, 0, 0, 0, 2, 1, 80, 3, 1, 1, 0, 11);
    v[12] = row(0, 0, 0, 1, 1, 1, 84, 7, 1, 1, 0, 11);
    v[13] = row(1, 84, 7, 0, 1, 1, 84, 7, 1, 1, 0, 11);
    v[14] = row(0, 0, 0, 1, 0, 0, 84, 7, 1, 1, 0, 11);
    v[15] = row(0, 0, 0, 1, 0, 0, 84, 7, 1, 1, 0, 11);
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1;
    for (int i = 0; i < 16; i++) begin
      step(v[i].mw, v[i].a, v[i].d, v[i].rd);
      chk_all($sformatf("row%0d", i), v[i].cnt, v[i].rv, v[i].ea, v[i].ed, v[i].dn, v[i].ps, v[i].fc, v[i].cyc, 0);
    end
    restart();
    step(1, 84, 5, 0);
    chk_all("bad_data", 1, 1, 84, 5, 1, 0, 1, 1, 0);
    step(1, 84, 7, 0);
    chk_all("after_fail", 1, 1, 84, 5, 1, 0, 1, 1, 0);
    restart();
    repeat (15) step(0, 0, 0, 0);
    chk_all("pre_timeout", 0, 0, 0, 0, 0, 0, 0, 15, 0);
    step(0, 0, 0, 0);
    chk_all("timeout", 0, 0, 0, 0, 1, 0, 2, 16, 0);
    step(0, 0, 0, 0);
    chk("timeout_frozen", cycles, 16);
    restart();
    for (int i = 0; i < 9; i++) step(1, 100 + i, i, 0);
    chk_all("full", 8, 1, 100, 0, 0, 0, 0, 9, 1);
    step(1, 200, 55, 1);
    chk_all("full_push_pop", 8, 1, 101, 1, 0, 0, 0, 10, 1);
    for (int k = 0; k < 7; k++) begin
      exp_a[k] = 101 + k;
      exp_d[k] = 1 + k;
    end
    exp_a[7] = 200;
    exp_d[7] = 55;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d.addr", k), rd_addr, exp_a[k]);
      chk($sformatf("drain%0d.data", k), rd_data, exp_d[k]);
      step(0, 0, 0, 1);
    end
    chk("drained.count", 32'(count), 0);
    chk("drained.rd_valid", 32'(rd_valid), 0);
    chk("drained.hold_addr", rd_addr, 200);
    chk("drained.overflow", 32'(overflow), 1);
    restart();
    step(1, 90, 9, 0);
    step(0, 0, 0, 0);
    chk("pre_async.count", 32'(count), 1);
    #2;
    reset = 0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef STORE_MONITOR_XCHECK_EN
    restart();
    step(1, 50, 1, 0);
    memwrite = 1;
    dataadr = 60;
    writedata = 'x;
    @(posedge clk);
    #1;
    memwrite = 0;
    writedata = 0;
    chk_all("xbus", 1, 1, 50, 1, 1, 0, 3, 2, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
